// File: rtl/ibus_dma_if.sv
// Memory-side and iobuf-side bus bundle for ibus_dma.
// The master modport is the DMA engine; slave is the memory/iobuf side.
interface ibus_dma_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_adr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;
  logic [15:0] mem_rdata;
  logic        ren;
  logic [15:0] ibus_radr;
  logic [15:0] ibus_rdata;
  logic        wen;
  logic [15:0] ibus_wadr;
  logic [15:0] ibus_wdata;

  modport master (
    output mem_req, mem_we, mem_adr, mem_wdata, ren, ibus_radr, wen, ibus_wadr, ibus_wdata,
    input  mem_gnt, mem_rdata, ibus_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_adr, mem_wdata, ren, ibus_radr, wen, ibus_wadr, ibus_wdata,
    output mem_gnt, mem_rdata, ibus_rdata
  );
endinterface

// File: rtl/ibus_dma.sv
// Block copy engine between CPU data memory and the systolic iobuf bus,
// with optional auto-start write after a memory->iobuf load.
module ibus_dma #(
  parameter int          LEN_W     = 10,
  parameter logic [15:0] START_ADR = 16'hFFF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_we,
  input  logic [2:0]       csr_adr,
  input  logic [15:0]      csr_wdata,
  output logic [15:0]      csr_rdata,
  ibus_dma_if.master       bus,
  output logic             irq
);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, KICK, DONE} state_t;

  state_t           state;
  logic [15:0]      src_q, dst_q;
  logic [LEN_W-1:0] len_q;
  logic             dir_q, auto_q;
  logic [15:0]      cur_src, cur_dst;
  logic [LEN_W-1:0] cur_cnt;
  logic             cur_dir, cur_auto;
  logic             done_q;

  logic        busy, csr_wr, go;
  logic [15:0] nxt_src, nxt_dst;

  assign busy    = (state != IDLE);
  assign csr_wr  = csr_we && !busy;
  assign go      = csr_wr && (csr_adr == 3'd3) && csr_wdata[0];
  assign nxt_src = cur_src + 16'd1;
  assign nxt_dst = cur_dst + 16'd1;
  assign irq     = done_q;

  // Programming registers; frozen while a transfer is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      dir_q  <= 1'b0;
      auto_q <= 1'b0;
    end else if (csr_wr) begin
      case (csr_adr)
        3'd0: src_q <= csr_wdata;
        3'd1: dst_q <= csr_wdata;
        3'd2: len_q <= csr_wdata[LEN_W-1:0];
        3'd3: begin
          dir_q  <= csr_wdata[1];
          auto_q <= csr_wdata[2];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_adr)
      3'd0: csr_rdata = src_q;
      3'd1: csr_rdata = dst_q;
      3'd2: csr_rdata[LEN_W-1:0] = len_q;
      3'd3: csr_rdata[2:1] = {auto_q, dir_q};
      3'd4: begin
        csr_rdata[0]          = busy;
        csr_rdata[1]          = done_q;
        csr_rdata[6 +: LEN_W] = cur_cnt;
      end
      default: ;
    endcase
  end

  // Transfer FSM. Bus outputs are registered and set on entry to the state
  // that owns them, so each strobe lines up exactly with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cur_src        <= '0;
      cur_dst        <= '0;
      cur_cnt        <= '0;
      cur_dir        <= 1'b0;
      cur_auto       <= 1'b0;
      done_q         <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_adr    <= '0;
      bus.mem_wdata  <= '0;
      bus.ren        <= 1'b0;
      bus.ibus_radr  <= '0;
      bus.wen        <= 1'b0;
      bus.ibus_wadr  <= '0;
      bus.ibus_wdata <= '0;
    end else begin
      if (csr_we && (csr_adr == 3'd4) && csr_wdata[1]) done_q <= 1'b0;
      case (state)
        IDLE: if (go) begin
          done_q   <= 1'b0;
          cur_src  <= src_q;
          cur_dst  <= dst_q;
          cur_cnt  <= len_q;
          cur_dir  <= csr_wdata[1];
          cur_auto <= csr_wdata[2];
          if (len_q == '0) begin
            state <= DONE;
          end else begin
            state <= RD;
            if (csr_wdata[1]) begin
              bus.ren       <= 1'b1;
              bus.ibus_radr <= src_q;
            end else begin
              bus.mem_req <= 1'b1;
              bus.mem_we  <= 1'b0;
              bus.mem_adr <= src_q;
            end
          end
        end
        RD: begin
          if (cur_dir) begin
            bus.ren <= 1'b0;
            state   <= RWAIT;
          end else if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            state       <= RWAIT;
          end
        end
        RWAIT: begin
          state <= WR;
          if (cur_dir) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_adr   <= cur_dst;
            bus.mem_wdata <= bus.ibus_rdata;
          end else begin
            bus.wen        <= 1'b1;
            bus.ibus_wadr  <= cur_dst;
            bus.ibus_wdata <= bus.mem_rdata;
          end
        end
        WR: if (!cur_dir || bus.mem_gnt) begin
          bus.wen     <= 1'b0;
          bus.mem_req <= 1'b0;
          bus.mem_we  <= 1'b0;
          cur_src     <= nxt_src;
          cur_dst     <= nxt_dst;
          cur_cnt     <= cur_cnt - LEN_W'(1);
          if (cur_cnt == LEN_W'(1)) begin
            if (!cur_dir && cur_auto) begin
              state          <= KICK;
              bus.wen        <= 1'b1;
              bus.ibus_wadr  <= START_ADR;
              bus.ibus_wdata <= 16'h0001;
            end else begin
              state <= DONE;
            end
          end else begin
            state <= RD;
            if (cur_dir) begin
              bus.ren       <= 1'b1;
              bus.ibus_radr <= nxt_src;
            end else begin
              bus.mem_req <= 1'b1;
              bus.mem_adr <= nxt_src;
            end
          end
        end
        KICK: begin
          bus.wen <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          done_q <= 1'b1;  // after the W1C above, so a same-cycle clear loses
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibus_dma.sv
// Directed bench for ibus_dma: memory returns adr^0x1010, iobuf reads come
// from a small table; bus activity is logged mid-cycle into queues.
module tb_ibus_dma;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csr_we = 1'b0;
  logic [2:0]  csr_adr = '0;
  logic [15:0] csr_wdata = '0;
  logic [15:0] csr_rdata;
  logic        irq;

  ibus_dma_if bus ();

  ibus_dma dut (
    .clk(clk), .rst(rst), .csr_we(csr_we), .csr_adr(csr_adr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0, nwen = 0, nren = 0, nreq = 0, overlap = 0;
  logic [31:0] wq[$];
  logic [31:0] mq[$];
  logic [15:0] rq[$];
  int          wcyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Mid-cycle bus monitor and memory/iobuf responder.
  always @(negedge clk) begin
    cyc++;
    if (int'(bus.ren) + int'(bus.wen) + int'(bus.mem_req) > 1) overlap++;
    if (bus.wen) begin
      nwen++;
      wq.push_back({bus.ibus_wadr, bus.ibus_wdata});
      wcyc.push_back(cyc);
    end
    if (bus.ren) begin
      nren++;
      rq.push_back(bus.ibus_radr);
      case (bus.ibus_radr)
        16'h8000: bus.ibus_rdata = 16'hA5A5;
        16'h8001: bus.ibus_rdata = 16'h5A5A;
        default:  bus.ibus_rdata = bus.ibus_radr;
      endcase
    end
    if (bus.mem_req) begin
      nreq++;
      if (bus.mem_gnt) begin
        if (bus.mem_we) mq.push_back({bus.mem_adr, bus.mem_wdata});
        else            bus.mem_rdata = bus.mem_adr ^ 16'h1010;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    csr_we = 1'b1; csr_adr = a; csr_wdata = d;
    @(posedge clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    csr_adr = a; #1;
    d = csr_rdata;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [15:0] s;
    int to = 1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      rd(3'd4, s);
      if (!s[0]) begin to = 0; break; end
    end
    chk(tag, to, 0);
  endtask

  task automatic clr_logs();
    wq.delete(); mq.delete(); rq.delete(); wcyc.delete();
  endtask

  logic [15:0] v;
  int n0, n1, n2;
  logic stall_ok;

  initial begin
    bus.mem_gnt = 1'b1;
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {bus.mem_req, bus.mem_we, bus.ren, bus.wen, irq}, 5'b0);
    rd(3'd4, v); chk("rst_status", v, 16'h0000);
    rst = 1'b0;
    rd(3'd0, v); chk("rst_src", v, 16'h0000);
    rd(3'd3, v); chk("rst_ctrl", v, 16'h0000);

    // Load: 4 words, 3 cycles each, done one cycle after DONE state
    wr(3'd0, 16'h0100); wr(3'd1, 16'h0000); wr(3'd2, 16'd4);
    clr_logs();
    wr(3'd3, 16'h0001);
    repeat (12) @(posedge clk);
    #1; rd(3'd4, v); chk("load_status_c12", v, 16'h0001);
    @(posedge clk); #1;
    rd(3'd4, v); chk("load_status_c13", v, 16'h0002);
    chk("load_irq", irq, 1'b1);
    chk("load_nwen", wq.size(), 4);
    for (int k = 0; k < 4 && k < wq.size(); k++)
      chk($sformatf("load_w%0d", k), wq[k], {16'(k), 16'h1110 + 16'(k)});
    if (wcyc.size() == 4) chk("load_spacing", wcyc[3] - wcyc[0], 9);
    rd(3'd0, v); chk("load_src_kept", v, 16'h0100);

    // Unload: iobuf -> memory
    wr(3'd4, 16'h0002);
    rd(3'd4, v); chk("w1c_clear", v, 16'h0000);
    wr(3'd0, 16'h8000); wr(3'd1, 16'h0200); wr(3'd2, 16'd2);
    clr_logs();
    wr(3'd3, 16'h0003);
    rd(3'd4, v); chk("unload_remain", v, 16'h0081);
    wait_idle("unload_timeout", 40);
    chk("unload_nren", rq.size(), 2);
    if (rq.size() == 2) begin
      chk("unload_r0", rq[0], 16'h8000);
      chk("unload_r1", rq[1], 16'h8001);
    end
    chk("unload_nmw", mq.size(), 2);
    if (mq.size() == 2) begin
      chk("unload_m0", mq[0], 32'h0200_A5A5);
      chk("unload_m1", mq[1], 32'h0201_5A5A);
    end
    chk("unload_nwen", wq.size(), 0);
    @(posedge clk); #1; chk("unload_irq", irq, 1'b1);

    // Auto-start kick after a single-word load
    wr(3'd4, 16'h0002);
    wr(3'd0, 16'h0120); wr(3'd1, 16'h0010); wr(3'd2, 16'd1);
    clr_logs();
    wr(3'd3, 16'h0005);
    wait_idle("auto_timeout", 40);
    chk("auto_nwen", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("auto_w0", wq[0], 32'h0010_1130);
      chk("auto_kick", wq[1], 32'hFFF0_0001);
      chk("auto_gap", wcyc[1] - wcyc[0], 1);
    end
    @(posedge clk); #1; chk("auto_irq", irq, 1'b1);

    // Zero length: no bus traffic, done next cycle
    wr(3'd4, 16'h0002);
    wr(3'd2, 16'd0);
    n0 = nreq; n1 = nren; n2 = nwen;
    wr(3'd3, 16'h0001);
    rd(3'd4, v); chk("zero_busy", v, 16'h0001);
    @(posedge clk); #1;
    rd(3'd4, v); chk("zero_done", v, 16'h0002);
    chk("zero_traffic", (nreq - n0) + (nren - n1) + (nwen - n2), 0);

    // Stall on grant plus destination wrap
    wr(3'd4, 16'h0002);
    wr(3'd0, 16'h0040); wr(3'd1, 16'hFFFF); wr(3'd2, 16'd2);
    clr_logs();
    bus.mem_gnt = 1'b0;
    wr(3'd3, 16'h0001);
    stall_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.mem_req && !bus.mem_we && bus.mem_adr == 16'h0040 && !bus.ren && !bus.wen))
        stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("stall_hold", stall_ok, 1'b1);
    chk("stall_no_ibus", wq.size() + rq.size(), 0);
    bus.mem_gnt = 1'b1;
    wait_idle("wrap_timeout", 40);
    chk("wrap_nwen", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("wrap_w0", wq[0], 32'hFFFF_1050);
      chk("wrap_w1", wq[1], 32'h0000_1051);
    end

    // Writes and go while busy are ignored
    @(posedge clk); #1;
    wr(3'd4, 16'h0002);
    wr(3'd0, 16'h0100); wr(3'd1, 16'h0300); wr(3'd2, 16'd3);
    clr_logs();
    wr(3'd3, 16'h0001);
    wr(3'd2, 16'd7);
    wr(3'd3, 16'h0001);
    wait_idle("busy_timeout", 60);
    rd(3'd2, v); chk("busy_len_kept", v, 16'd3);
    chk("busy_nwen", wq.size(), 3);

    // W1C landing in the DONE cycle loses to the set
    @(posedge clk); #1;
    wr(3'd2, 16'd1);
    wr(3'd3, 16'h0001);
    repeat (2) @(posedge clk);
    wr(3'd4, 16'h0002);
    rd(3'd4, v); chk("w1c_vs_set", v, 16'h0002);

    // Reset mid-transfer
    wr(3'd2, 16'd8);
    wr(3'd3, 16'h0001);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_strobes", {bus.mem_req, bus.mem_we, bus.ren, bus.wen, irq}, 5'b0);
    chk("midrst_adr", {bus.mem_adr, bus.ibus_wadr}, 32'h0);
    rd(3'd4, v); chk("midrst_status", v, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    n0 = nreq + nren + nwen;
    repeat (10) @(posedge clk);
    #1; chk("midrst_quiet", nreq + nren + nwen - n0, 0);

    chk("exclusive", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
